// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and CPU transaction state type for the VRAM arbiter
package vram_pkg;
  localparam int VRAM_AW = 16;
  localparam int VRAM_DW = 16;
  localparam int UNDERRUN_W = 16;
  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_DATA, C_ACK} cpu_state_t;
endpackage

// File: rtl/vram_sat_cnt.sv
// vram_sat_cnt: saturating up-counter with synchronous clear
module vram_sat_cnt #(
  parameter int W = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] LIM = W'(MAX);
  // count up until the limit, clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != LIM) cnt <= cnt + W'(1);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between VGA scanout and CPU; define VRAM_ARB_STATS_EN for underrun and CPU-grant counters
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLK1_50,
  input  logic                  RST_N,
  input  logic                  VGA_REQ,
  input  logic [AW-1:0]         VGA_ADDR,
  output logic                  VGA_VALID,
  output logic [DW-1:0]         VGA_RDATA,
  input  logic                  CPU_REQ,
  input  logic                  CPU_WE,
  input  logic [AW-1:0]         CPU_ADDR,
  input  logic [DW-1:0]         CPU_WDATA,
  output logic                  CPU_ACK,
  output logic [DW-1:0]         CPU_RDATA,
  output logic [AW-1:0]         MEM_ADDR,
  output logic                  MEM_WE,
  output logic [DW-1:0]         MEM_WDATA,
  input  logic [DW-1:0]         MEM_RDATA,
  output logic [UNDERRUN_W-1:0] UNDERRUN_CNT
);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  cpu_state_t state;
  logic we_q, cpu_idle, starve, grant_cpu, grant_vga, vga_p1, vga_p2;
  logic [7:0] wait_cnt;
  assign cpu_idle = state == C_IDLE;
  assign starve = wait_cnt == SMAX && CPU_REQ && cpu_idle;
  assign grant_cpu = starve || (!VGA_REQ && CPU_REQ && cpu_idle);
  assign grant_vga = VGA_REQ && !starve;
  vram_sat_cnt #(.W(8), .MAX(STARVE_MAX)) u_wait (
    .clk(CLK1_50), .rst_n(RST_N), .clr(grant_cpu || !CPU_REQ),
    .inc(CPU_REQ && cpu_idle && !grant_cpu), .cnt(wait_cnt)
  );
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_grant_cnt;
  vram_sat_cnt #(.W(UNDERRUN_W), .MAX((1 << UNDERRUN_W) - 1)) u_under (
    .clk(CLK1_50), .rst_n(RST_N), .clr(1'b0), .inc(starve && VGA_REQ), .cnt(UNDERRUN_CNT)
  );
  vram_sat_cnt #(.W(16), .MAX(65535)) u_grant (
    .clk(CLK1_50), .rst_n(RST_N), .clr(1'b0), .inc(grant_cpu), .cnt(cpu_grant_cnt)
  );
`else
  assign UNDERRUN_CNT = '0;
`endif
  // drive the RAM port from whichever requester won; address holds when idle
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      MEM_ADDR <= '0;
      MEM_WE <= 1'b0;
      MEM_WDATA <= '0;
    end else begin
      MEM_WE <= grant_cpu && CPU_WE;
      MEM_ADDR <= grant_cpu ? CPU_ADDR : grant_vga ? VGA_ADDR : MEM_ADDR;
      MEM_WDATA <= grant_cpu ? CPU_WDATA : MEM_WDATA;
    end
  // fixed two-edge scanout pipeline: address out, RAM read, capture
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      vga_p1 <= 1'b0;
      vga_p2 <= 1'b0;
      VGA_VALID <= 1'b0;
      VGA_RDATA <= '0;
    end else begin
      vga_p1 <= grant_vga;
      vga_p2 <= vga_p1;
      VGA_VALID <= vga_p2;
      VGA_RDATA <= vga_p2 ? MEM_RDATA : VGA_RDATA;
    end
  // CPU transaction sequencer with registered ack and read data
  always_ff @(posedge CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      state <= C_IDLE;
      we_q <= 1'b0;
      CPU_ACK <= 1'b0;
      CPU_RDATA <= '0;
    end else begin
      CPU_ACK <= (state == C_ISSUE && we_q) || state == C_DATA;
      CPU_RDATA <= state == C_DATA ? MEM_RDATA : CPU_RDATA;
      we_q <= grant_cpu ? CPU_WE : we_q;
      case (state)
        C_IDLE:  state <= grant_cpu ? C_ISSUE : C_IDLE;
        C_ISSUE: state <= we_q ? C_ACK : C_DATA;
        C_DATA:  state <= C_ACK;
        default: state <= C_IDLE;
      endcase
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a transaction-level model
module tb_vram_arbiter;
  localparam int SM = 8;
  logic clk = 0, rst_n = 0;
  logic vreq = 0, creq = 0, cwe = 0;
  logic [15:0] vaddr = 0, caddr = 0, cwdata = 0, mrdata = 0;
  logic vvalid, cack, mwe;
  logic [15:0] vrdata, crdata, maddr, mwdata, under;
  int total = 0, bad = 0;
  logic [15:0] ram [logic [15:0]];
  logic [15:0] mm [logic [15:0]];
  int cyc = 0, cpu_free = 0, w = 0, s;
  logic idle, starve, gc, gv;
  logic [15:0] m_addr = 0, m_under = 0, m_gcnt = 0;
  logic e_mwe [8], e_vv [8], e_ack [8], e_rd [8];
  logic [15:0] e_wd [8], e_vd [8], e_crd [8];
  logic p_req = 0, p_we = 0;
  logic [15:0] p_a = 0, p_d = 0;

  vram_arbiter #(.AW(16), .DW(16), .STARVE_MAX(SM)) dut (
    .CLK1_50(clk), .RST_N(rst_n),
    .VGA_REQ(vreq), .VGA_ADDR(vaddr), .VGA_VALID(vvalid), .VGA_RDATA(vrdata),
    .CPU_REQ(creq), .CPU_WE(cwe), .CPU_ADDR(caddr), .CPU_WDATA(cwdata),
    .CPU_ACK(cack), .CPU_RDATA(crdata),
    .MEM_ADDR(maddr), .MEM_WE(mwe), .MEM_WDATA(mwdata), .MEM_RDATA(mrdata),
    .UNDERRUN_CNT(under)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_rd(logic [15:0] a);
    return ram.exists(a) ? ram[a] : a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] mm_rd(logic [15:0] a);
    return mm.exists(a) ? mm[a] : a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_slot(input int k);
    e_mwe[k] = 0; e_vv[k] = 0; e_ack[k] = 0; e_rd[k] = 0;
    e_wd[k] = 0; e_vd[k] = 0; e_crd[k] = 0;
  endtask

  // synchronous read-first VRAM macro
  initial forever begin
    @(posedge clk);
    mrdata <= ram_rd(maddr);
    if (mwe) ram[maddr] = mwdata;
  end

  // transaction-level reference: grant decision per edge, results scheduled by latency
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; cpu_free = 0; w = 0; m_addr = 0; m_under = 0; m_gcnt = 0;
      for (int i = 0; i < 8; i++) clr_slot(i);
    end else begin
      cyc++;
      clr_slot((cyc + 2) % 8);
      idle = cyc >= cpu_free;
      starve = w == SM && creq && idle;
      gc = starve || (!vreq && creq && idle);
      gv = vreq && !starve;
      if (gc || !creq) w = 0;
      else if (idle && w < SM) w++;
`ifdef VRAM_ARB_STATS_EN
      if (starve && vreq && m_under != 16'hFFFF) m_under++;
      if (gc && m_gcnt != 16'hFFFF) m_gcnt++;
`endif
      if (gv) begin
        m_addr = vaddr;
        e_vv[(cyc + 2) % 8] = 1;
        e_vd[(cyc + 2) % 8] = mm_rd(vaddr);
      end
      if (gc) begin
        m_addr = caddr;
        if (cwe) begin
          e_mwe[cyc % 8] = 1;
          e_wd[cyc % 8] = cwdata;
          mm[caddr] = cwdata;
          e_ack[(cyc + 1) % 8] = 1;
          cpu_free = cyc + 3;
        end else begin
          e_ack[(cyc + 2) % 8] = 1;
          e_rd[(cyc + 2) % 8] = 1;
          e_crd[(cyc + 2) % 8] = mm_rd(caddr);
          cpu_free = cyc + 4;
        end
      end
    end
  end

  // per-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      s = cyc % 8;
      chk("mem_we", 16'(mwe), 16'(e_mwe[s]));
      chk("mem_addr", maddr, m_addr);
      if (e_mwe[s]) chk("mem_wdata", mwdata, e_wd[s]);
      chk("vga_valid", 16'(vvalid), 16'(e_vv[s]));
      if (e_vv[s]) chk("vga_rdata", vrdata, e_vd[s]);
      chk("cpu_ack", 16'(cack), 16'(e_ack[s]));
      if (e_rd[s]) chk("cpu_rdata", crdata, e_crd[s]);
      chk("underrun", under, m_under);
`ifdef VRAM_ARB_STATS_EN
      chk("grant_cnt", dut.cpu_grant_cnt, m_gcnt);
`endif
    end
  end

  // requester must keep CPU fields stable while a request is pending
  initial forever begin
    @(posedge clk);
    if (rst_n && creq && p_req && !cack) begin
      total++;
      if (caddr !== p_a || cwe !== p_we || cwdata !== p_d) begin
        bad++;
        $display("FAIL cpu_protocol: fields changed while request pending at %0t", $time);
      end
    end
    p_req = creq && rst_n; p_a = caddr; p_we = cwe; p_d = cwdata;
  end

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                            output int we_c, output int ack_c, output logic [15:0] rd);
    we_c = -1; ack_c = -1; rd = 0;
    creq = 1; cwe = we; caddr = a; cwdata = d;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mwe && we_c < 0) we_c = c;
      if (cack) begin ack_c = c; rd = crdata; creq = 0; end
    end
    creq = 0;
    if (ack_c < 0) begin
      total++; bad++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack within 40 cycles");
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, maddr, 0);
    chk({tag, "_mem_we"}, 16'(mwe), 0);
    chk({tag, "_mem_wdata"}, mwdata, 0);
    chk({tag, "_vga_valid"}, 16'(vvalid), 0);
    chk({tag, "_vga_rdata"}, vrdata, 0);
    chk({tag, "_cpu_ack"}, 16'(cack), 0);
    chk({tag, "_cpu_rdata"}, crdata, 0);
    chk({tag, "_underrun"}, under, 0);
  endtask

  task automatic vga_stream();
    int first;
    logic [15:0] got [$];
    logic [15:0] exp [4];
    exp = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6};
    first = -1;
    for (int i = 0; i < 8; i++) begin
      vreq = i < 4; vaddr = 16'h0010 + 16'(i);
      @(negedge clk);
      if (vvalid) begin
        if (first < 0) first = i;
        got.push_back(vrdata);
      end
    end
    vreq = 0;
    chk("vga_first_valid", 16'(first), 2);
    chk("vga_valid_count", 16'(got.size()), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("vga_stream_data", got[k], exp[k]);
  endtask

  task automatic cpu_rw();
    int we_c, ack_c;
    logic [15:0] rd;
    cpu_access(1, 16'h0200, 16'h1234, we_c, ack_c, rd);
    chk("wr_we_cycle", 16'(we_c), 1);
    chk("wr_ack_cycle", 16'(ack_c), 2);
    @(negedge clk);
    cpu_access(0, 16'h0200, 16'h0000, we_c, ack_c, rd);
    chk("rd_no_we", 16'(we_c), 16'hFFFF);
    chk("rd_ack_cycle", 16'(ack_c), 3);
    chk("rd_data", rd, 16'h1234);
  endtask

  task automatic starve_test();
    int grant_c, ack_c, zeros;
    logic [15:0] rd;
    grant_c = -1; ack_c = -1; zeros = 0; rd = 0;
    creq = 1; cwe = 0; caddr = 16'h0005;
    for (int c = 1; c <= 18; c++) begin
      vreq = c <= 16; vaddr = 16'h0100 + 16'(c);
      @(negedge clk);
      if (maddr == 16'h0005 && grant_c < 0) grant_c = c;
      if (cack) begin ack_c = c; rd = crdata; creq = 0; end
      if (c >= 3 && !vvalid) zeros++;
    end
    vreq = 0; creq = 0;
    chk("starve_grant_edge", 16'(grant_c), 9);
    chk("starve_ack_cycle", 16'(ack_c), 11);
    chk("starve_rdata", rd, 16'hA5A0);
    chk("starve_vga_gaps", 16'(zeros), 1);
`ifdef VRAM_ARB_STATS_EN
    chk("starve_underrun", under, 1);
`else
    chk("starve_underrun", under, 0);
`endif
  endtask

  task automatic simul_test();
    int we_c, ack_c;
    we_c = -1; ack_c = -1;
    creq = 1; cwe = 1; caddr = 16'h0300; cwdata = 16'hBEEF;
    for (int c = 1; c <= 10; c++) begin
      vreq = c <= 3; vaddr = 16'h0040 + 16'(c);
      @(negedge clk);
      if (mwe && we_c < 0) we_c = c;
      if (cack) begin ack_c = c; creq = 0; end
    end
    vreq = 0; creq = 0;
    chk("simul_we_cycle", 16'(we_c), 4);
    chk("simul_ack_cycle", 16'(ack_c), 5);
  endtask

  task automatic held_test();
    int acks, first, last, mingap;
    acks = 0; first = -1; last = -100; mingap = 100;
    creq = 1; cwe = 0; caddr = 16'h0200;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (cack) begin
        acks++;
        if (first < 0) first = c;
        if (c - last < mingap) mingap = c - last;
        last = c;
        chk("held_rdata", crdata, 16'h1234);
      end
    end
    creq = 0;
    @(negedge clk);
    @(negedge clk);
    chk("held_ack_count", 16'(acks), 3);
    chk("held_first_ack", 16'(first), 3);
    chk("held_min_gap", 16'(mingap), 4);
  endtask

  task automatic reset_test();
    int acks;
    acks = 0;
    creq = 1; cwe = 0; caddr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 0;
    #1 check_zero("async_rst");
    creq = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cack) acks++;
    end
    chk("rst_no_ack", 16'(acks), 0);
  endtask

  task automatic random_phase();
    int pct;
    for (int c = 0; c < 3000; c++) begin
      pct = ((c / 400) % 2 == 1) ? 95 : 60;
      vreq = $urandom_range(0, 99) < pct;
      vaddr = 16'($urandom_range(0, 63));
      if (!creq && $urandom_range(0, 3) == 0) begin
        creq = 1;
        cwe = 1'($urandom_range(0, 1));
        caddr = 16'($urandom_range(0, 63));
        cwdata = 16'($urandom);
      end
      if (c == 1500) begin
        #2 rst_n = 0;
        @(negedge clk);
        creq = 0;
        rst_n = 1;
      end
      @(negedge clk);
      if (cack && $urandom_range(0, 2) != 0) creq = 0;
    end
    vreq = 0; creq = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1 check_zero("reset");
    @(negedge clk);
    vga_stream();
    cpu_rw();
    @(negedge clk);
    starve_test();
    @(negedge clk);
    simul_test();
    held_test();
    reset_test();
    random_phase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the VGA scanout reader and the CPU load/store port.
- Sits between the CPU core, the VGA timing/pixel unit and the VRAM macro inside the CPU top level.
- VGA gets fixed priority with deterministic latency.
- CPU uses a req/ack handshake and has a starvation guard, so a saturated scanout cannot lock it out.

Parameters:
- AW, 16, address width of VRAM and both requesters.
- DW, 16, data width.
- STARVE_MAX, 8, consecutive blocked CPU cycles before CPU preempts VGA; legal range 1..255.

Ports:
- CLK1_50  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- VGA_REQ  in  1  scanout read request, one word per cycle.
- VGA_ADDR  in  AW  scanout read address.
- VGA_VALID  out  1  VGA_RDATA valid.
- VGA_RDATA  out  DW  scanout read data.
- CPU_REQ  in  1  CPU access request, held until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ is high.
- CPU_ADDR  in  AW  CPU address.
- CPU_WDATA  in  DW  CPU write data.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  DW  read data, valid while CPU_ACK is high.
- MEM_ADDR  out  AW  VRAM address.
- MEM_WE  out  1  VRAM write enable.
- MEM_WDATA  out  DW  VRAM write data.
- MEM_RDATA  in  DW  VRAM read data, valid one cycle after the address is presented.
- UNDERRUN_CNT  out  16  count of dropped VGA requests.

Behaviour:
- Registers: all outputs registered; all requests sampled on the rising edge of CLK1_50.
- Reset: RST_N low clears immediately, without a clock:
  - MEM_ADDR, MEM_WDATA, VGA_RDATA, CPU_RDATA = 0;
  - MEM_WE, VGA_VALID, CPU_ACK = 0;
  - UNDERRUN_CNT = 0; CPU FSM = C_IDLE; wait counter = 0.
  - An in-flight transaction is discarded; no ACK and no VALID are produced for it after release.
- Arbitration at each edge E0, in priority order:
  - (a) starve = (wait_cnt == STARVE_MAX) and CPU_REQ and FSM in C_IDLE → grant CPU. A simultaneous VGA_REQ is dropped (not queued) and UNDERRUN_CNT increments.
  - (b) else VGA_REQ → grant VGA.
  - (c) else CPU_REQ and FSM in C_IDLE → grant CPU.
  - (d) else no grant: MEM_WE = 0, MEM_ADDR holds its last value.
- VGA path:
  - After a grant at E0, MEM_ADDR = VGA_ADDR and MEM_WE = 0.
  - VGA_VALID = 1 and VGA_RDATA = MEM_RDATA for exactly the cycle after E2. Fixed latency 2.
  - Back-to-back grants stream one word per cycle.
- CPU FSM:
  - C_IDLE: on grant → C_ISSUE; MEM_ADDR/MEM_WE/MEM_WDATA driven from CPU_* for one cycle.
  - C_ISSUE: if write → C_ACK (RAM writes at E1). If read → C_DATA.
  - C_DATA: capture MEM_RDATA into CPU_RDATA → C_ACK.
  - C_ACK: CPU_ACK = 1 for this one cycle; → C_IDLE. CPU_REQ sampled at this edge is ignored.
  - Latency: write ACK after E1; read ACK after E2.
  - Back-to-back minimum access period: 3 cycles for writes, 4 for reads.
- MEM_WE width: high for exactly one cycle per CPU write; never asserted for VGA.
- Wait counter:
  - Increments at each edge where CPU_REQ = 1, FSM in C_IDLE and CPU is not granted.
  - Clears on CPU grant or when CPU_REQ = 0.
  - Saturates at STARVE_MAX.
- UNDERRUN_CNT saturates at 16'hFFFF.
- Requester changing CPU_ADDR/CPU_WE/CPU_WDATA mid-transaction is a protocol error; behaviour is unspecified (bench assertion).

Optional Feature:
- VRAM_ARB_STATS_EN defined:
  - UNDERRUN_CNT counts as above.
  - An internal 16-bit saturating CPU-grant counter is added, exposed as hierarchical signal cpu_grant_cnt.
- VRAM_ARB_STATS_EN undefined:
  - UNDERRUN_CNT tied to 0; no counter flops synthesized.
  - Arbitration, dropping and latency are unchanged.

Decomposition:
- Package vram_pkg holds:
  - VRAM_AW = 16 and VRAM_DW = 16 constants;
  - cpu_state_t enum {C_IDLE, C_ISSUE, C_DATA, C_ACK};
  - UNDERRUN_W = 16.
- One natural sub-module: vram_sat_cnt, a parameterized saturating counter with increment and clear. It is used for the wait counter and the stats counters.

Test Plan:
- Reset: assert RST_N = 0 mid-CPU-read → all outputs 0 within the same cycle; no CPU_ACK after release.
- VGA stream: VGA_REQ = 1 for 4 cycles, addresses 0x0010..0x0013, RAM preloaded with data = address ^ 0xA5A5 → VGA_VALID high 4 cycles starting 2 cycles after the first edge, data 0xA5B5, 0xA5B4, 0xA5B7, 0xA5B6.
- CPU write then read, VGA idle:
  - write 0x1234 to 0x0200 → MEM_WE pulses 1 cycle, CPU_ACK 1 cycle later;
  - read 0x0200 → CPU_ACK 2 cycles after grant with CPU_RDATA = 0x1234.
- Starvation: VGA_REQ held 1, CPU_REQ read at 0x0005, STARVE_MAX = 8 → CPU granted at the 9th edge, exactly one VGA slot shows VGA_VALID = 0, UNDERRUN_CNT = 1.
- Simultaneous request with wait_cnt = 0 → VGA wins, CPU granted the first cycle VGA_REQ drops.
- CPU_REQ held high across C_ACK → next grant no earlier than the edge after the ACK cycle; no duplicate ACK.
